// File: rtl/active_list_reader.sv
// Walks the per-line active sprite BRAM (indices 0..count-1) and streams the
// {tilemap, bitmap} pairs out through a 2-entry FIFO. Option: ACTIVE_READER_SKIP_NULL_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing BRAM reads while credit allows
// DRAIN | all reads issued; waiting for the last read and the FIFO to empty
module active_list_reader #(
    parameter int IDX_W  = 9,
    parameter int FIFO_D = 2
) (
    input  logic             clk_draw,
    input  logic             rst_draw_n,
    input  logic             start,
    input  logic [IDX_W:0]   count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] read_index,
    input  logic [35:0]      read_tilemap_addr,
    input  logic [35:0]      read_bitmap_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [35:0]      out_tilemap_addr,
    output logic [35:0]      out_bitmap_addr,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [35:0]      tilemap;
        logic [35:0]      bitmap;
        logic [IDX_W-1:0] index;
        logic             last;
    } entry_t;

    state_t           state_q, state_d;
    logic [IDX_W:0]   count_q;
    logic [IDX_W:0]   cnt_q;
    logic [IDX_W:0]   cnt_inc;
    logic [IDX_W-1:0] read_index_q;
    logic             last_q;
    logic             inflight_q;

    entry_t           fifo_q [FIFO_D];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       occ_q;

    entry_t           head;
    entry_t           cap;
    logic             keep;
    logic             pop;
    logic             push;
    logic             issue;
    logic             done_c;
    logic [2:0]       credit;

    assign cnt_inc = cnt_q + {{IDX_W{1'b0}}, 1'b1};

`ifdef ACTIVE_READER_SKIP_NULL_EN
    assign keep = (read_bitmap_addr != '0);
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        cap.tilemap = read_tilemap_addr;
        cap.bitmap  = read_bitmap_addr;
        cap.index   = read_index_q;
        cap.last    = last_q;
    end

    // A read may only be issued if, counting it, every outstanding entry still
    // fits in the FIFO even if the consumer stalls from now on.
    always_comb begin
        pop     = (occ_q != 2'd0) && out_ready;
        push    = inflight_q && keep;
        credit  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        issue   = (state_q == RUN) && (cnt_q != count_q) && (credit <= 3'(FIFO_D - 1));
        state_d = state_q;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = (count == '0) ? DRAIN : RUN;
            end
            RUN: begin
                if (cnt_q == count_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (!inflight_q && occ_q == 2'd0) begin
                    state_d = IDLE;
                    done_c  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            done_c  = 1'b0;
        end
    end

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            cnt_q        <= '0;
            read_index_q <= '0;
            last_q       <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= issue;
                if (state_q == IDLE && start) begin
                    count_q <= count;
                    cnt_q   <= '0;
                end
                if (issue) begin
                    read_index_q <= cnt_q[IDX_W-1:0];
                    cnt_q        <= cnt_inc;
                    last_q       <= (cnt_inc == count_q);
                end
            end
        end
    end

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            for (int i = 0; i < FIFO_D; i++) fifo_q[i] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (abort) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= cap;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + 2'(push) - 2'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk_draw) disable iff (!rst_draw_n)
        !(push && !pop && !abort && occ_q == 2'(FIFO_D)));

    assign head             = fifo_q[rd_ptr_q];
    assign busy             = (state_q != IDLE);
    assign done             = done_c;
    assign read_index       = read_index_q;
    assign out_valid        = (occ_q != 2'd0);
    assign out_tilemap_addr = out_valid ? head.tilemap : '0;
    assign out_bitmap_addr  = out_valid ? head.bitmap  : '0;
    assign out_index        = out_valid ? head.index   : '0;
    assign out_last         = out_valid && head.last;

endmodule
